// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 event queue.
// Events are packed as {ext, brk, code}.
package kbd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } kbd_state_t;

  localparam logic [7:0] KBD_PFX_EXT   = 8'hE0;
  localparam logic [7:0] KBD_PFX_BRK   = 8'hF0;
  localparam logic [7:0] KBD_PFX_PAUSE = 8'hE1;
  localparam logic [7:0] KBD_BAT_OK    = 8'hAA;
  localparam logic [7:0] KBD_ERR_00    = 8'h00;
  localparam logic [7:0] KBD_ERR_FF    = 8'hFF;

  localparam int KBD_EV_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_ev_t;

  function automatic logic kbd_is_err(input logic [7:0] b);
    return (b == KBD_ERR_00) || (b == KBD_ERR_FF);
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: power-of-two FWFT queue with wrap-bit pointers.
// Registered count/full/afull track the pointers exactly.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2,
  parameter int W         = KBD_EV_W,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         afull,
  output logic [AW:0]  count
);

  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] AF  = (AW+1)'(AFULL_LVL);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_q, rd_q, wr_n, rd_n, cnt_n;
  logic         do_pop, do_push, full_n;

  assign empty   = (wr_q == rd_q);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_q[AW-1:0]];

  // next pointers and the status they imply
  always_comb begin
    wr_n   = do_push ? wr_q + ONE : wr_q;
    rd_n   = do_pop  ? rd_q + ONE : rd_q;
    cnt_n  = wr_n - rd_n;
    full_n = (wr_n[AW] != rd_n[AW]) &&
             (wr_n[AW-1:0] == rd_n[AW-1:0]);
  end

  // pointer and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
      full  <= 1'b0;
      afull <= (AFULL_LVL == 0);
    end else begin
      wr_q  <= wr_n;
      rd_q  <= rd_n;
      count <= cnt_n;
      full  <= full_n;
      afull <= (cnt_n >= AF);
    end
  end

  // entry storage, contents never gate full/empty
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kbd_event_queue.sv
// kbd_event_queue: Set-2 prefix folding parser + event FIFO.
// Optional typematic repeat filter: define KBD_REPEAT_FILTER_EN.
module kbd_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          CLOCK_50,
  input  logic          RST,
  input  logic [7:0]    RX_DATA,
  input  logic          RX_VALID,
  input  logic          POP,
  input  logic          CLR_OVF,
  output logic          EV_VALID,
  output logic [7:0]    EV_CODE,
  output logic          EV_EXT,
  output logic          EV_BREAK,
  output logic [CW-1:0] COUNT,
  output logic          FULL,
  output logic          AFULL,
  output logic          OVERFLOW
);

  kbd_state_t st_q, st_n;
  kbd_ev_t    ev_n, ev_q, head;
  logic       emit, keep, ev_v_q;
  logic       is_ext, is_brk, is_err, idle_drop;
  logic       empty;

  assign is_ext    = (RX_DATA == KBD_PFX_EXT);
  assign is_brk    = (RX_DATA == KBD_PFX_BRK);
  assign is_err    = kbd_is_err(RX_DATA);
  assign idle_drop = is_err || (RX_DATA == KBD_BAT_OK) ||
                     (RX_DATA == KBD_PFX_PAUSE);

  // parser next state and event emit
  always_comb begin
    st_n        = st_q;
    emit        = 1'b0;
    ev_n.ext    = 1'b0;
    ev_n.brk    = 1'b0;
    ev_n.code   = RX_DATA;
    if (RX_VALID) begin
      unique case (st_q)
        S_IDLE: begin
          unique case (1'b1)
            is_ext:    st_n = S_EXT;
            is_brk:    st_n = S_BRK;
            idle_drop: st_n = S_IDLE;
            default:   emit = 1'b1;
          endcase
        end
        S_EXT: begin
          unique case (1'b1)
            is_brk: st_n = S_EXT_BRK;
            is_ext: st_n = S_EXT;
            is_err: st_n = S_IDLE;
            default: begin
              emit     = 1'b1;
              ev_n.ext = 1'b1;
              st_n     = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          st_n = S_IDLE;
          if (!(is_err || is_ext || is_brk)) begin
            emit     = 1'b1;
            ev_n.brk = 1'b1;
          end
        end
        S_EXT_BRK: begin
          st_n = S_IDLE;
          if (!(is_err || is_ext || is_brk)) begin
            emit     = 1'b1;
            ev_n.ext = 1'b1;
            ev_n.brk = 1'b1;
          end
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  // parser state register
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) st_q <= S_IDLE;
    else     st_q <= st_n;
  end

`ifdef KBD_REPEAT_FILTER_EN
  logic       rec_v;
  logic       rec_ext;
  logic [7:0] rec_code;
  logic       rec_match;

  assign rec_match = rec_v && (rec_ext == ev_n.ext) &&
                     (rec_code == ev_n.code);
  assign keep      = emit && !(rec_match && !ev_n.brk);

  // last-make record: repeats dropped, matching break clears
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      rec_v    <= 1'b0;
      rec_ext  <= 1'b0;
      rec_code <= 8'h00;
    end else if (emit) begin
      if (!ev_n.brk) begin
        rec_v    <= 1'b1;
        rec_ext  <= ev_n.ext;
        rec_code <= ev_n.code;
      end else if (rec_match) begin
        rec_v <= 1'b0;
      end
    end
  end
`else
  assign keep = emit;
`endif

  // one-cycle event stage ahead of the queue
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      ev_v_q <= 1'b0;
      ev_q   <= '0;
    end else begin
      ev_v_q <= keep;
      ev_q   <= ev_n;
    end
  end

  kbd_event_fifo #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL),
    .W         (KBD_EV_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst   (RST),
    .push  (ev_v_q),
    .din   (ev_q),
    .pop   (POP),
    .dout  (head),
    .empty (empty),
    .full  (FULL),
    .afull (AFULL),
    .count (COUNT)
  );

  // sticky overflow; a drop in the clear cycle keeps it set
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST)                        OVERFLOW <= 1'b0;
    else if (ev_v_q && FULL && !POP) OVERFLOW <= 1'b1;
    else if (CLR_OVF)               OVERFLOW <= 1'b0;
  end

  assign EV_VALID = !empty;
  assign EV_CODE  = empty ? 8'h00 : head.code;
  assign EV_EXT   = !empty && head.ext;
  assign EV_BREAK = !empty && head.brk;

endmodule

// File: tb/tb_kbd_event_queue.sv
// tb_kbd_event_queue: directed checks of parser, queue and overflow.
// Runs at DEPTH=4; repeat filter section follows KBD_REPEAT_FILTER_EN.
module tb_kbd_event_queue;

  logic       CLOCK_50 = 1'b0;
  logic       RST      = 1'b1;
  logic [7:0] RX_DATA  = 8'h00;
  logic       RX_VALID = 1'b0;
  logic       POP      = 1'b0;
  logic       CLR_OVF  = 1'b0;
  logic       EV_VALID;
  logic [7:0] EV_CODE;
  logic       EV_EXT;
  logic       EV_BREAK;
  logic [2:0] COUNT;
  logic       FULL;
  logic       AFULL;
  logic       OVERFLOW;

  int nchk  = 0;
  int nfail = 0;

  kbd_event_queue #(
    .DEPTH     (4),
    .AFULL_LVL (2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .POP      (POP),
    .CLR_OVF  (CLR_OVF),
    .EV_VALID (EV_VALID),
    .EV_CODE  (EV_CODE),
    .EV_EXT   (EV_EXT),
    .EV_BREAK (EV_BREAK),
    .COUNT    (COUNT),
    .FULL     (FULL),
    .AFULL    (AFULL),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic pop1();
    POP = 1'b1;
    tick();
    POP = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] head();
    return {22'd0, EV_EXT, EV_BREAK, EV_CODE};
  endfunction

  initial begin
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk("rst_count", COUNT, 0);
    chk("rst_valid", EV_VALID, 0);
    chk("rst_full", FULL, 0);
    chk("rst_afull", AFULL, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_head", head(), 0);

    send(8'h1C);
    chk("lat_not_yet", EV_VALID, 0);
    tick();
    chk("lat_valid", EV_VALID, 1);
    chk("make_1c", head(), 10'h01C);
    send(8'hF0);
    send(8'h1C);
    tick();
    chk("cnt_two", COUNT, 2);
    chk("afull_two", AFULL, 1);
    pop1();
    chk("break_1c", head(), 10'h11C);
    chk("cnt_one", COUNT, 1);
    chk("afull_one", AFULL, 0);
    pop1();
    chk("drain_valid", EV_VALID, 0);

    send(8'hE0);
    send(8'h75);
    send(8'h00);
    send(8'hFF);
    send(8'hAA);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    tick();
    chk("ext_cnt", COUNT, 2);
    chk("ext_make", head(), 10'h275);
    pop1();
    chk("ext_break", head(), 10'h375);
    pop1();
    chk("ext_empty", COUNT, 0);

    pop1();
    chk("pop_empty_cnt", COUNT, 0);
    chk("pop_empty_v", EV_VALID, 0);

    for (int i = 1; i <= 6; i++) send(8'(i));
    tick();
    tick();
    chk("ovf_cnt", COUNT, 4);
    chk("ovf_full", FULL, 1);
    chk("ovf_flag", OVERFLOW, 1);
    chk("ovf_head", head(), 10'h001);
    send(8'h07);
    pop1();
    chk("pp_cnt", COUNT, 4);
    chk("pp_full", FULL, 1);
    chk("pp_head", head(), 10'h002);
    chk("pp_ovf_keep", OVERFLOW, 1);
    pop1();
    chk("pp_h3", head(), 10'h003);
    pop1();
    chk("pp_h4", head(), 10'h004);
    pop1();
    chk("pp_tail", head(), 10'h007);
    pop1();
    chk("pp_empty", COUNT, 0);
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    chk("clr_ovf", OVERFLOW, 0);

    for (int i = 0; i < 10; i++) begin
      send(8'h10 + 8'(i));
      tick();
      chk("wrap_head", head(), 32'h10 + 32'(i));
      chk("wrap_cnt1", COUNT, 1);
      pop1();
      chk("wrap_cnt0", COUNT, 0);
    end

    for (int i = 0; i < 5; i++) send(8'h21 + 8'(i));
    tick();
    tick();
    chk("pre_rst_ovf", OVERFLOW, 1);
    send(8'hE0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_cnt", COUNT, 0);
    chk("mid_rst_ovf", OVERFLOW, 0);
    chk("mid_rst_v", EV_VALID, 0);
    send(8'h1C);
    tick();
    chk("after_rst_ev", head(), 10'h01C);
    pop1();

    RST = 1'b1;
    tick();
    RST = 1'b0;
`ifdef KBD_REPEAT_FILTER_EN
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    send(8'h1C);
    tick();
    chk("rep_cnt", COUNT, 3);
    chk("rep_ev0", head(), 10'h01C);
    pop1();
    chk("rep_ev1", head(), 10'h11C);
    pop1();
    chk("rep_ev2", head(), 10'h01C);
    chk("rep_ovf", OVERFLOW, 0);
`else
    send(8'h1C);
    send(8'h1C);
    tick();
    chk("norep_cnt", COUNT, 2);
    chk("norep_ev0", head(), 10'h01C);
    pop1();
    chk("norep_ev1", head(), 10'h01C);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
